// File: rtl/apb_master_bridge_if.sv
// Bundle of the host command/response handshake and the APB initiator signals.
// The master modport is the bridge's view; the slave modport is the host/APB side.
interface apb_master_bridge_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
);
    logic              cmd_valid;
    logic              cmd_ready;
    logic              cmd_write;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;

    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;

    logic              psel;
    logic              penable;
    logic              pwrite;
    logic [ADDR_W-1:0] paddr;
    logic [DATA_W-1:0] pwdata;
    logic [DATA_W-1:0] prdata;
    logic              pready;
    logic              pslverr;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output cmd_ready,
        output rsp_valid, rsp_rdata, rsp_err,
        output psel, penable, pwrite, paddr, pwdata,
        input  prdata, pready, pslverr
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  cmd_ready,
        input  rsp_valid, rsp_rdata, rsp_err,
        input  psel, penable, pwrite, paddr, pwdata,
        output prdata, pready, pslverr
    );
endinterface

// File: rtl/apb_master_bridge.sv
// APB initiator: turns single host commands into SETUP/ACCESS transfers with a one-cycle response strobe.
// Optional ACCESS wait-state timeout is enabled by defining APB_TIMEOUT_EN.
module apb_master_bridge #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input logic                pclk,
    input logic                preset_n,
    apb_master_bridge_if.master bus
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_e;

    if (TIMEOUT < 1) begin : g_timeout_check
        $error("apb_master_bridge: TIMEOUT must be at least 1");
    end

    state_e            state_q, state_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

`ifdef APB_TIMEOUT_EN
    localparam int WaitW = $clog2(TIMEOUT + 1);
    logic [WaitW-1:0]  wait_q, wait_d;
`endif

    always_comb begin
        state_d     = state_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
`ifdef APB_TIMEOUT_EN
        wait_d      = wait_q;
`endif

        case (state_q)
            IDLE: begin
                if (bus.cmd_valid) begin
                    pwrite_d = bus.cmd_write;
                    paddr_d  = bus.cmd_addr;
                    pwdata_d = bus.cmd_wdata;
                    state_d  = SETUP;
                end
            end
            SETUP: begin
                state_d = ACCESS;
`ifdef APB_TIMEOUT_EN
                wait_d  = '0;
`endif
            end
            ACCESS: begin
                // A real completion takes priority over a timeout reached in the same cycle.
                if (bus.pready) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = bus.pslverr;
                    rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
                end
`ifdef APB_TIMEOUT_EN
                else if (wait_q == WaitW'(TIMEOUT)) begin
                    state_d     = IDLE;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b1;
                    rsp_rdata_d = '0;
                end else begin
                    wait_d = wait_q + 1'b1;
                end
`endif
            end
            default: state_d = IDLE;
        endcase

        // Bus strobes are registered, so derive them from where the FSM is heading.
        psel_d    = (state_d != IDLE);
        penable_d = (state_d == ACCESS);
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q     <= IDLE;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

`ifdef APB_TIMEOUT_EN
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            wait_q <= '0;
        end else begin
            wait_q <= wait_d;
        end
    end
`endif

    assign bus.cmd_ready = (state_q == IDLE);
    assign bus.psel      = psel_q;
    assign bus.penable   = penable_q;
    assign bus.pwrite    = pwrite_q;
    assign bus.paddr     = paddr_q;
    assign bus.pwdata    = pwdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_master_bridge.sv
// Directed bench for apb_master_bridge: inputs change and outputs are sampled on the falling edge.
// The timeout scenario runs when APB_TIMEOUT_EN is defined; otherwise the indefinite wait is checked.
module tb_apb_master_bridge;

    logic pclk;
    logic preset_n;
    int   total;
    int   bad;

    apb_master_bridge_if #(.ADDR_W(8), .DATA_W(8)) bus ();

    apb_master_bridge #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(16)) dut (
        .pclk     (pclk),
        .preset_n (preset_n),
        .bus      (bus)
    );

    initial pclk = 1'b0;
    always #5 pclk = ~pclk;

    task automatic tick();
        @(posedge pclk);
        @(negedge pclk);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("[TB] FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic wr, input logic [7:0] addr,
                                 input logic [7:0] wdata);
        bus.cmd_valid = valid;
        bus.cmd_write = wr;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wdata;
    endtask

    task automatic checkBus(input string tag, input logic sel, input logic en, input logic rv);
        checkOutput({tag, ".psel"}, 32'(bus.psel), 32'(sel));
        checkOutput({tag, ".penable"}, 32'(bus.penable), 32'(en));
        checkOutput({tag, ".rsp_valid"}, 32'(bus.rsp_valid), 32'(rv));
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        preset_n = 1'b0;
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        bus.prdata  = 8'h00;
        bus.pready  = 1'b0;
        bus.pslverr = 1'b0;

        // Reset values
        tick();
        checkBus("reset", 1'b0, 1'b0, 1'b0);
        checkOutput("reset.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        checkOutput("reset.paddr", 32'(bus.paddr), 32'h00);
        checkOutput("reset.rsp_rdata", 32'(bus.rsp_rdata), 32'h00);
        checkOutput("reset.rsp_err", 32'(bus.rsp_err), 32'd0);
        preset_n = 1'b1;
        tick();

        // Write, zero wait states
        applyStimulus(1'b1, 1'b1, 8'h03, 8'hA5);
        bus.pready = 1'b1;
        checkOutput("wr.cmd_ready_T", 32'(bus.cmd_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkBus("wr.setup", 1'b1, 1'b0, 1'b0);
        checkOutput("wr.cmd_ready_setup", 32'(bus.cmd_ready), 32'd0);
        checkOutput("wr.paddr", 32'(bus.paddr), 32'h03);
        checkOutput("wr.pwdata", 32'(bus.pwdata), 32'hA5);
        checkOutput("wr.pwrite", 32'(bus.pwrite), 32'd1);
        tick();
        checkBus("wr.access", 1'b1, 1'b1, 1'b0);
        checkOutput("wr.paddr_access", 32'(bus.paddr), 32'h03);
        tick();
        checkBus("wr.rsp", 1'b0, 1'b0, 1'b1);
        checkOutput("wr.rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("wr.rsp_rdata", 32'(bus.rsp_rdata), 32'h00);
        checkOutput("wr.cmd_ready_rsp", 32'(bus.cmd_ready), 32'd1);
        tick();
        checkBus("wr.after", 1'b0, 1'b0, 1'b0);
        checkOutput("wr.paddr_hold", 32'(bus.paddr), 32'h03);
        checkOutput("wr.pwdata_hold", 32'(bus.pwdata), 32'hA5);

        // Read with 3 wait states; prdata only valid when pready is high
        applyStimulus(1'b1, 1'b0, 8'h05, 8'h00);
        bus.pready = 1'b0;
        bus.prdata = 8'hEE;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkBus("rd.setup", 1'b1, 1'b0, 1'b0);
        tick();
        for (int i = 0; i < 4; i++) begin
            checkBus($sformatf("rd.access%0d", i), 1'b1, 1'b1, 1'b0);
            checkOutput($sformatf("rd.paddr%0d", i), 32'(bus.paddr), 32'h05);
            checkOutput($sformatf("rd.pwrite%0d", i), 32'(bus.pwrite), 32'd0);
            if (i == 3) begin
                bus.pready = 1'b1;
                bus.prdata = 8'h3C;
            end
            tick();
        end
        checkBus("rd.rsp", 1'b0, 1'b0, 1'b1);
        checkOutput("rd.rsp_rdata", 32'(bus.rsp_rdata), 32'h3C);
        checkOutput("rd.rsp_err", 32'(bus.rsp_err), 32'd0);
        bus.prdata = 8'h00;
        tick();
        checkOutput("rd.rdata_hold", 32'(bus.rsp_rdata), 32'h3C);

        // Slave error on a write, then a clean read
        applyStimulus(1'b1, 1'b1, 8'h07, 8'h44);
        bus.pslverr = 1'b1;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        checkBus("err.rsp", 1'b0, 1'b0, 1'b1);
        checkOutput("err.rsp_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("err.rsp_rdata", 32'(bus.rsp_rdata), 32'h00);
        bus.pslverr = 1'b0;
        tick();
        checkOutput("err.rsp_valid_drop", 32'(bus.rsp_valid), 32'd0);
        checkOutput("err.err_hold", 32'(bus.rsp_err), 32'd1);
        applyStimulus(1'b1, 1'b0, 8'h07, 8'h00);
        bus.prdata = 8'h5A;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        checkOutput("clean.rsp_valid", 32'(bus.rsp_valid), 32'd1);
        checkOutput("clean.rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("clean.rsp_rdata", 32'(bus.rsp_rdata), 32'h5A);
        tick();

        // Back-to-back with cmd_valid held high; cmd changes outside IDLE must be ignored
        applyStimulus(1'b1, 1'b1, 8'h10, 8'h11);
        tick();
        applyStimulus(1'b1, 1'b1, 8'h20, 8'h22);
        checkBus("b2b.setup1", 1'b1, 1'b0, 1'b0);
        checkOutput("b2b.paddr1", 32'(bus.paddr), 32'h10);
        tick();
        checkOutput("b2b.paddr1_access", 32'(bus.paddr), 32'h10);
        checkOutput("b2b.pwdata1_access", 32'(bus.pwdata), 32'h11);
        tick();
        checkBus("b2b.rsp1", 1'b0, 1'b0, 1'b1);
        checkOutput("b2b.cmd_ready_rsp1", 32'(bus.cmd_ready), 32'd1);
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        checkBus("b2b.setup2", 1'b1, 1'b0, 1'b0);
        checkOutput("b2b.paddr2", 32'(bus.paddr), 32'h20);
        checkOutput("b2b.pwdata2", 32'(bus.pwdata), 32'h22);
        tick();
        checkBus("b2b.access2", 1'b1, 1'b1, 1'b0);
        tick();
        checkBus("b2b.rsp2", 1'b0, 1'b0, 1'b1);
        tick();

        // Reset asserted during an ACCESS wait state
        applyStimulus(1'b1, 1'b0, 8'h30, 8'h00);
        bus.pready = 1'b0;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        tick();
        checkBus("rst.waiting", 1'b1, 1'b1, 1'b0);
        preset_n = 1'b0;
        #1;
        checkBus("rst.immediate", 1'b0, 1'b0, 1'b0);
        checkOutput("rst.cmd_ready", 32'(bus.cmd_ready), 32'd1);
        bus.pready = 1'b1;
        tick();
        preset_n = 1'b1;
        tick();
        checkBus("rst.after", 1'b0, 1'b0, 1'b0);
        checkOutput("rst.cmd_ready_after", 32'(bus.cmd_ready), 32'd1);
        checkOutput("rst.paddr", 32'(bus.paddr), 32'h00);

`ifdef APB_TIMEOUT_EN
        // Timeout: 16 wait cycles counted, abort at the end of the 17th ACCESS cycle
        applyStimulus(1'b1, 1'b0, 8'h40, 8'h00);
        bus.pready = 1'b0;
        bus.prdata = 8'h99;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 17; i++) begin
            checkBus($sformatf("to.access%0d", i), 1'b1, 1'b1, 1'b0);
            tick();
        end
        checkBus("to.rsp", 1'b0, 1'b0, 1'b1);
        checkOutput("to.rsp_err", 32'(bus.rsp_err), 32'd1);
        checkOutput("to.rsp_rdata", 32'(bus.rsp_rdata), 32'h00);
        tick();

        // pready arriving in the cycle the counter reaches TIMEOUT completes normally
        applyStimulus(1'b1, 1'b0, 8'h41, 8'h00);
        bus.prdata = 8'h77;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 17; i++) begin
            if (i == 16) bus.pready = 1'b1;
            tick();
        end
        checkBus("to.edge_rsp", 1'b0, 1'b0, 1'b1);
        checkOutput("to.edge_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("to.edge_rdata", 32'(bus.rsp_rdata), 32'h77);
        tick();
`else
        // Without the timeout the bridge waits indefinitely for pready
        applyStimulus(1'b1, 1'b0, 8'h40, 8'h00);
        bus.pready = 1'b0;
        bus.prdata = 8'h66;
        tick();
        applyStimulus(1'b0, 1'b0, 8'h00, 8'h00);
        tick();
        for (int i = 0; i < 40; i++) tick();
        checkBus("nto.still_waiting", 1'b1, 1'b1, 1'b0);
        bus.pready = 1'b1;
        tick();
        checkBus("nto.rsp", 1'b0, 1'b0, 1'b1);
        checkOutput("nto.rsp_err", 32'(bus.rsp_err), 32'd0);
        checkOutput("nto.rsp_rdata", 32'(bus.rsp_rdata), 32'h66);
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
